// File: rtl/rvsteel_spi_peripheral.sv
// SPI peripheral (target) endpoint: oversamples sclk/cs/pico on the system clock, shifts a
// fabric-supplied word out on poci and delivers each received word with a one-cycle valid pulse.
module rvsteel_spi_peripheral #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          CPOL       = 1'b0,
    parameter bit          CPHA       = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  pico,
    input  logic                  cs,
    output logic                  poci,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun
);

    localparam int unsigned         CntWidth = $clog2(DATA_WIDTH);
    localparam logic [CntWidth-1:0] LastBit  = CntWidth'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    logic [1:0] sclk_sync, cs_sync, pico_sync;
    logic       sclk_prev, cs_prev;
    logic       sclk_s, cs_s, pico_s;
    logic       cs_fall, cs_rise, lead_edge, trail_edge, sample_ev, shift_ev;

    state_e state_q, state_d;
    logic   do_start, do_abort, do_sample, do_shift, do_complete, do_load;

    logic [CntWidth-1:0]   cnt_q;
    logic [DATA_WIDTH-1:0] nb_q, rx_shift_q, hold_q, load_word, nb_src;
    logic                  hold_full_q, tx_write;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_sync <= {2{CPOL}};
            cs_sync   <= 2'b11;
            pico_sync <= 2'b00;
            sclk_prev <= CPOL;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            cs_sync   <= {cs_sync[0], cs};
            pico_sync <= {pico_sync[0], pico};
            sclk_prev <= sclk_sync[1];
            cs_prev   <= cs_sync[1];
        end
    end

    assign sclk_s = sclk_sync[1];
    assign cs_s   = cs_sync[1];
    assign pico_s = pico_sync[1];

    assign cs_fall    = cs_prev && !cs_s;
    assign cs_rise    = !cs_prev && cs_s;
    assign lead_edge  = (sclk_prev == CPOL) && (sclk_s != CPOL);
    assign trail_edge = (sclk_prev != CPOL) && (sclk_s == CPOL);
    assign sample_ev  = CPHA ? trail_edge : lead_edge;
    assign shift_ev   = CPHA ? lead_edge : trail_edge;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cs_fall) state_d = StActive;
            StActive: if (cs_rise) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        do_start  = 1'b0;
        do_abort  = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        unique case (state_q)
            StIdle: begin
                do_start = cs_fall;
                // In mode CPHA=0 the MSB must be on poci before the first leading edge.
                do_shift = cs_fall && (CPHA == 1'b0);
            end
            StActive: begin
                do_abort  = cs_rise;
                do_sample = sample_ev && !cs_rise;
                do_shift  = shift_ev && !cs_rise;
            end
            default: ;
        endcase
    end

    assign do_complete = do_sample && (cnt_q == LastBit);
    assign do_load     = do_start || do_complete;
    assign load_word   = hold_full_q ? hold_q : '0;
    assign nb_src      = do_load ? load_word : nb_q;
    assign tx_write    = tx_valid && !hold_full_q;
    assign tx_ready    = !hold_full_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            poci        <= 1'b0;
            nb_q        <= '0;
            rx_shift_q  <= '0;
            cnt_q       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            rx_valid    <= do_complete;
            tx_underrun <= do_load && !hold_full_q;

            if (do_shift) begin
                poci <= nb_src[DATA_WIDTH-1];
                nb_q <= nb_src << 1;
            end else if (do_load) begin
                nb_q <= load_word;
            end

            if (do_sample) begin
                rx_shift_q <= {rx_shift_q[DATA_WIDTH-2:0], pico_s};
                cnt_q      <= do_complete ? '0 : cnt_q + 1'b1;
            end

            if (do_complete) begin
                rx_data <= {rx_shift_q[DATA_WIDTH-2:0], pico_s};
            end

            // A deselect drops the partial word; the holding register is left untouched.
            if (do_abort) begin
                poci       <= 1'b0;
                rx_shift_q <= '0;
                cnt_q      <= '0;
            end

            // An empty-register load coinciding with a write leaves the written word held.
            hold_full_q <= (hold_full_q && !do_load) || tx_write;
            if (tx_write) begin
                hold_q <= tx_data;
            end
        end
    end

endmodule

// File: tb/tb_rvsteel_spi_peripheral.sv
// Bench for rvsteel_spi_peripheral: a mode-0 and a mode-3 instance driven by a bit-level SPI
// controller, checked against a word-level model of the holding register and receive stream.
module tb_rvsteel_spi_peripheral;

    localparam int Half = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] sclk_v, cs_v, tx_valid_v, poci_v, tx_ready_v, rx_valid_v, tx_underrun_v;
    logic       pico;
    logic [7:0] tx_data;
    logic [7:0] rx_data_v [2];

    int checks = 0;
    int failures = 0;
    int act = 0;

    logic [7:0] exp_rx_q [$];
    logic       hold_full_m [2];
    logic [7:0] hold_word_m [2];
    logic [7:0] cur_tx [2];
    logic [7:0] last_rx_m [2];
    int         urun_m [2];
    int         dut_urun [2];
    int         dut_rxv [2];
    int         idle_cnt [2];

    always #5 clock = ~clock;

    rvsteel_spi_peripheral #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .clock(clock), .reset(reset), .sclk(sclk_v[0]), .pico(pico), .cs(cs_v[0]),
        .poci(poci_v[0]), .tx_data(tx_data), .tx_valid(tx_valid_v[0]),
        .tx_ready(tx_ready_v[0]), .rx_data(rx_data_v[0]), .rx_valid(rx_valid_v[0]),
        .tx_underrun(tx_underrun_v[0])
    );

    rvsteel_spi_peripheral #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
        .clock(clock), .reset(reset), .sclk(sclk_v[1]), .pico(pico), .cs(cs_v[1]),
        .poci(poci_v[1]), .tx_data(tx_data), .tx_valid(tx_valid_v[1]),
        .tx_ready(tx_ready_v[1]), .rx_data(rx_data_v[1]), .rx_valid(rx_valid_v[1]),
        .tx_underrun(tx_underrun_v[1])
    );

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            hold_full_m[d] = 1'b0;
            hold_word_m[d] = 8'h00;
            cur_tx[d]      = 8'h00;
            last_rx_m[d]   = 8'h00;
        end
        exp_rx_q.delete();
    endtask

    // Every load takes the held word, or zeros plus one underrun if nothing is held.
    task automatic model_load(input int d);
        if (hold_full_m[d]) begin
            cur_tx[d]      = hold_word_m[d];
            hold_full_m[d] = 1'b0;
        end else begin
            cur_tx[d] = 8'h00;
            urun_m[d]++;
        end
    endtask

    task automatic tx_write(input int d, input logic [7:0] w);
        int n;
        n = 0;
        while (tx_ready_v[d] !== 1'b1 && n < 20) begin
            wait_clk(1);
            n++;
        end
        chk("tx_ready_before_write", 32'(tx_ready_v[d]), 32'd1);
        if (tx_ready_v[d] === 1'b1) begin
            tx_data       = w;
            tx_valid_v[d] = 1'b1;
            wait_clk(1);
            tx_valid_v[d] = 1'b0;
            chk("tx_ready_after_write", 32'(tx_ready_v[d]), 32'd0);
            hold_full_m[d] = 1'b1;
            hold_word_m[d] = w;
        end
    endtask

    task automatic cs_low(input int d);
        act     = d;
        cs_v[d] = 1'b0;
        model_load(d);
        wait_clk(6);
    endtask

    task automatic cs_high(input int d);
        wait_clk(5);
        cs_v[d] = 1'b1;
        wait_clk(8);
    endtask

    // d=0 is mode 0 (sample on rising), d=1 is mode 3 (shift on falling, sample on rising).
    task automatic xfer(input int d, input logic [7:0] mosi, input int nbits, input int wr_bit,
                        input logic [7:0] wr_val, output logic [7:0] miso);
        logic       cp;
        logic [7:0] exp;
        cp   = (d == 1);
        exp  = cur_tx[d] >> (8 - nbits);
        miso = 8'h00;
        if (nbits == 8) exp_rx_q.push_back(mosi);
        for (int k = 0; k < nbits; k++) begin
            if (k == wr_bit) tx_write(d, wr_val);
            if (!cp) begin
                pico = mosi[7-k];
                wait_clk(Half);
                miso = {miso[6:0], poci_v[d]};
                sclk_v[d] = 1'b1;
                wait_clk(Half);
                sclk_v[d] = 1'b0;
            end else begin
                sclk_v[d] = 1'b0;
                pico = mosi[7-k];
                wait_clk(Half);
                miso = {miso[6:0], poci_v[d]};
                sclk_v[d] = 1'b1;
                wait_clk(Half);
            end
        end
        chk("miso_model", 32'(miso), 32'(exp));
        if (nbits == 8) model_load(d);
    endtask

    task automatic end_test(input int d);
        chk("rx_words_all_seen", 32'(exp_rx_q.size()), 32'd0);
        chk("underrun_model", 32'(dut_urun[d]), 32'(urun_m[d]));
    endtask

    initial begin
        logic ok_slot;
        logic [7:0] w;
        forever begin
            @(posedge clock);
            #1;
            if (!reset) begin
                for (int d = 0; d < 2; d++) begin
                    idle_cnt[d] = cs_v[d] ? idle_cnt[d] + 1 : 0;
                    if (tx_underrun_v[d]) dut_urun[d]++;
                    if (rx_valid_v[d]) begin
                        dut_rxv[d]++;
                        ok_slot = (d == act) && (exp_rx_q.size() != 0);
                        chk("rx_valid_wanted", 32'(ok_slot), 32'd1);
                        if (ok_slot) begin
                            w = exp_rx_q.pop_front();
                            chk("rx_data_word", 32'(rx_data_v[d]), 32'(w));
                            last_rx_m[d] = w;
                        end
                    end else begin
                        chk("rx_data_hold", 32'(rx_data_v[d]), 32'(last_rx_m[d]));
                    end
                    if (idle_cnt[d] >= 3) chk("poci_idle", 32'(poci_v[d]), 32'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m, m2;
        int u0, r0;
        sclk_v = 2'b10;
        cs_v = 2'b11;
        tx_valid_v = 2'b00;
        pico = 1'b0;
        tx_data = 8'h00;
        for (int d = 0; d < 2; d++) begin
            urun_m[d] = 0;
            dut_urun[d] = 0;
            dut_rxv[d] = 0;
            idle_cnt[d] = 0;
        end
        model_reset();
        wait_clk(3);
        for (int d = 0; d < 2; d++) begin
            chk("rst_poci", 32'(poci_v[d]), 32'd0);
            chk("rst_rx_data", 32'(rx_data_v[d]), 32'd0);
            chk("rst_rx_valid", 32'(rx_valid_v[d]), 32'd0);
            chk("rst_tx_ready", 32'(tx_ready_v[d]), 32'd1);
            chk("rst_tx_underrun", 32'(tx_underrun_v[d]), 32'd0);
        end
        reset = 1'b0;
        wait_clk(4);

        // Mode 0 single word; a second write keeps the end-of-word load from underrunning.
        u0 = dut_urun[0];
        r0 = dut_rxv[0];
        tx_write(0, 8'hA5);
        cs_low(0);
        xfer(0, 8'h3C, 8, 2, 8'h5A, m);
        cs_high(0);
        chk("m0_poci_bits", 32'(m), 32'hA5);
        chk("m0_rx_data", 32'(rx_data_v[0]), 32'h3C);
        chk("m0_rx_pulses", 32'(dut_rxv[0] - r0), 32'd1);
        chk("m0_tx_ready", 32'(tx_ready_v[0]), 32'd1);
        chk("m0_underruns", 32'(dut_urun[0] - u0), 32'd0);
        end_test(0);

        // Mode 3 back-to-back words in one frame.
        r0 = dut_rxv[1];
        tx_write(1, 8'h55);
        cs_low(1);
        xfer(1, 8'h81, 8, 3, 8'hF0, m);
        xfer(1, 8'h7E, 8, -1, 8'h00, m2);
        cs_high(1);
        chk("m3_poci_word1", 32'(m), 32'h55);
        chk("m3_poci_word2", 32'(m2), 32'hF0);
        chk("m3_rx_data", 32'(rx_data_v[1]), 32'h7E);
        chk("m3_rx_pulses", 32'(dut_rxv[1] - r0), 32'd2);
        end_test(1);

        // Underrun at select, nothing preloaded.
        u0 = dut_urun[0];
        cs_low(0);
        chk("ur_at_cs", 32'(dut_urun[0] - u0), 32'd1);
        xfer(0, 8'hFF, 8, 4, 8'h00, m);
        cs_high(0);
        chk("ur_poci_zero", 32'(m), 32'h00);
        chk("ur_rx_data", 32'(rx_data_v[0]), 32'hFF);
        chk("ur_pulses", 32'(dut_urun[0] - u0), 32'd1);
        end_test(0);

        // Abort after 5 bits; the word written mid-frame stays held for the next frame.
        r0 = dut_rxv[0];
        tx_write(0, 8'hFF);
        cs_low(0);
        xfer(0, 8'hC3, 5, 2, 8'h42, m);
        chk("ab_partial_bits", 32'(m), 32'h1F);
        wait_clk(Half);
        chk("ab_poci_before", 32'(poci_v[0]), 32'd1);
        cs_v[0] = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("ab_poci_3cyc", 32'(poci_v[0]), 32'd0);
        wait_clk(8);
        chk("ab_no_rx_valid", 32'(dut_rxv[0] - r0), 32'd0);
        chk("ab_word_kept", 32'(tx_ready_v[0]), 32'd0);
        cs_low(0);
        xfer(0, 8'h12, 8, -1, 8'h00, m);
        cs_high(0);
        chk("ab_next_poci", 32'(m), 32'h42);
        chk("ab_next_rx", 32'(rx_data_v[0]), 32'h12);
        end_test(0);

        // Asynchronous reset after bit 3.
        tx_write(0, 8'hFF);
        cs_low(0);
        xfer(0, 8'hA0, 3, 1, 8'h99, m);
        wait_clk(Half);
        chk("pre_rst_poci", 32'(poci_v[0]), 32'd1);
        chk("pre_rst_tx_ready", 32'(tx_ready_v[0]), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_poci", 32'(poci_v[0]), 32'd0);
        chk("arst_rx_data0", 32'(rx_data_v[0]), 32'd0);
        chk("arst_rx_data1", 32'(rx_data_v[1]), 32'd0);
        chk("arst_rx_valid", 32'(rx_valid_v[0]), 32'd0);
        chk("arst_tx_ready", 32'(tx_ready_v[0]), 32'd1);
        chk("arst_tx_underrun", 32'(tx_underrun_v[0]), 32'd0);
        model_reset();
        cs_v[0] = 1'b1;
        sclk_v[0] = 1'b0;
        pico = 1'b0;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(4);
        tx_write(0, 8'h3A);
        cs_low(0);
        xfer(0, 8'h69, 8, -1, 8'h00, m);
        cs_high(0);
        chk("post_rst_poci", 32'(m), 32'h3A);
        chk("post_rst_rx", 32'(rx_data_v[0]), 32'h69);
        end_test(0);
        end_test(1);

        wait_clk(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
